johnson_monitor: RTL

JOHNSON_MONITOR -- requirements
Module: johnson_monitor

---
 rtl/johnson_monitor.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/johnson_monitor.sv
// johnson_monitor
//   Watches the output of an upstream 4-bit Johnson counter. Each en=1 sample
//   is decoded to a phase index. The monitor also tracks whether the sequence
//   advances one phase at a time, locks onto a healthy sequence, counts
//   sequence errors while locked, and counts full revolutions.
//
// Parameters
//   LOCK_CNT  consecutive successor steps needed to lock (1..15)
//   ERR_W     width of the saturating error counter
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   johnson[3]  Johnson code from the upstream counter
//   en          sample strobe
//   clr_err     synchronous clear of err_cnt / err_sticky
//   phase[2:0]  decoded phase of the last legal sample
//   phase_oh[7] one-hot form of phase
//   code_ok     last sampled code was legal
//   locked      FSM is in LOCKED
//   seq_err     one-cycle pulse: illegal or out-of-sequence code while locked
//   err_sticky  set by seq_err, held until clr_err or reset
//   err_cnt     saturating count of seq_err pulses
//   rev_pulse   one-cycle pulse on each locked 7->0 step
//   rev_cnt     wrapping revolution count
module johnson_monitor #(
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       johnson,
    input  logic             en,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic [7:0]       phase_oh,
    output logic             code_ok,
    output logic             locked,
    output logic             seq_err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic             rev_pulse,
    output logic [7:0]       rev_cnt
);

    typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [2:0]       phase_q, phase_d;
    logic [7:0]       phase_oh_q, phase_oh_d;
    logic             code_ok_q, code_ok_d;
    logic             seq_err_q, seq_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             rev_pulse_q, rev_pulse_d;
    logic [7:0]       rev_cnt_q, rev_cnt_d;

    // Code decode
    logic       legal;
    logic [2:0] dec_phase;

    always_comb begin
        legal     = 1'b1;
        dec_phase = 3'd0;
        case (johnson)
            4'b0000: dec_phase = 3'd0;
            4'b0001: dec_phase = 3'd1;
            4'b0011: dec_phase = 3'd2;
            4'b0111: dec_phase = 3'd3;
            4'b1111: dec_phase = 3'd4;
            4'b1110: dec_phase = 3'd5;
            4'b1100: dec_phase = 3'd6;
            4'b1000: dec_phase = 3'd7;
            default: legal     = 1'b0;
        endcase
    end

    // Step and hold are only meaningful relative to a previous legal sample.
    // After reset or an illegal code (code_ok_q=0), the next legal code only
    // re-anchors the sequence. In LOCKED, code_ok_q is always 1, because an
    // illegal code always drops the FSM back to ACQUIRE.
    logic is_step, is_hold, wrap_step;

    always_comb begin
        is_step   = code_ok_q && legal && (dec_phase == phase_q + 3'd1);
        is_hold   = code_ok_q && legal && (dec_phase == phase_q);
        wrap_step = is_step && (phase_q == 3'd7);
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        phase_d      = phase_q;
        phase_oh_d   = phase_oh_q;
        code_ok_d    = code_ok_q;
        seq_err_d    = 1'b0;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        rev_pulse_d  = 1'b0;
        rev_cnt_d    = rev_cnt_q;

        if (en) begin
            code_ok_d = legal;
            if (legal) begin
                phase_d    = dec_phase;
                phase_oh_d = 8'd1 << dec_phase;
            end

            case (state_q)
                ACQUIRE: begin
                    if (is_step) begin
                        if (step_q + 4'd1 == LOCK_TGT) begin
                            state_d     = LOCKED;
                            step_d      = 4'd0;
                            // The locking step can itself complete a revolution.
                            rev_pulse_d = wrap_step;
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end else if (!is_hold) begin
                        step_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_step) begin
                        rev_pulse_d = wrap_step;
                    end else if (!is_hold) begin
                        state_d      = ACQUIRE;
                        step_d       = 4'd0;
                        seq_err_d    = 1'b1;
                        err_sticky_d = 1'b1;
                        if (err_cnt_q != ERR_MAX)
                            err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
                default: state_d = ACQUIRE;
            endcase

            if (rev_pulse_d)
                rev_cnt_d = rev_cnt_q + 8'd1;
        end

        // A clear in the same cycle as an error takes priority over the error.
        if (clr_err) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACQUIRE;
            step_q       <= 4'd0;
            phase_q      <= 3'd0;
            phase_oh_q   <= 8'h01;
            code_ok_q    <= 1'b0;
            seq_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            rev_pulse_q  <= 1'b0;
            rev_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            phase_q      <= phase_d;
            phase_oh_q   <= phase_oh_d;
            code_ok_q    <= code_ok_d;
            seq_err_q    <= seq_err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            rev_pulse_q  <= rev_pulse_d;
            rev_cnt_q    <= rev_cnt_d;
        end
    end

    assign phase      = phase_q;
    assign phase_oh   = phase_oh_q;
    assign code_ok    = code_ok_q;
    assign locked     = (state_q == LOCKED);
    assign seq_err    = seq_err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign rev_pulse  = rev_pulse_q;
    assign rev_cnt    = rev_cnt_q;

endmodule
